// File: rtl/uart_tx_arbiter_if.sv
// Bundle of the requester-side handshake and the UART transmitter pins.
// The slave modport is the arbiter's view. The master modport is the view of
// whatever sits on the other side: the byte producers and the transmitter.
interface uart_tx_arbiter_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]   req;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   ack;
  logic [NREQ-1:0]   done;
  logic              tx_en;
  logic              tx_wr;
  logic [7:0]        tx_data;
  logic              tx_busy;

  modport slave (
    input  req, req_data, tx_busy,
    output ack, done, tx_en, tx_wr, tx_data
  );

  modport master (
    output req, req_data, tx_busy,
    input  ack, done, tx_en, tx_wr, tx_data
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter among NREQ producers.
// It grants one requester, latches that requester's byte and strobes tx_wr.
// It then follows tx_busy through the frame and reports done, or reports
// err_timeout if the transmitter never starts. Every output is registered.
module uart_tx_arbiter #(
  parameter int NREQ          = 4,
  parameter int PTR_W         = 2,
  parameter int START_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  uart_tx_arbiter_if.slave bus,
  output logic [PTR_W-1:0] cur_owner,
  output logic             active,
  output logic             err_timeout
);

  localparam int                CNT_W    = $clog2(START_TIMEOUT) + 1;
  localparam int unsigned       NREQ_U   = NREQ;
  localparam logic [PTR_W-1:0]  LAST_RST = PTR_W'(NREQ - 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(START_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    GRANT,
    WRITE,
    WAIT_START,
    WAIT_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [PTR_W-1:0] last_grant_q, last_grant_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [NREQ-1:0]  ack_q, ack_d;
  logic [NREQ-1:0]  done_q, done_d;
  logic [PTR_W-1:0] owner_q, owner_d;
  logic             active_q, active_d;
  logic             err_q, err_d;
  logic             wr_q, wr_d;
  logic             en_q;
  logic [7:0]       data_q, data_d;

  logic             win_found;
  logic [PTR_W-1:0] win_idx;
  logic [PTR_W-1:0] scan_ptr;

  // Round-robin pick. Scan from last_grant+1 and wrap modulo NREQ, so the
  // most recently served requester is tried last.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_ptr  = '0;
    for (int unsigned i = 1; i <= NREQ_U; i++) begin
      scan_ptr = PTR_W'((32'(last_grant_q) + i) % NREQ_U);
      if (!win_found && bus.req[scan_ptr]) begin
        win_found = 1'b1;
        win_idx   = scan_ptr;
      end
    end
  end

  // Next-state and next-output logic. The outputs are registered, so each
  // pulse is decided on the transition into the cycle in which it is seen.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    ack_d        = '0;
    done_d       = '0;
    owner_d      = owner_q;
    active_d     = active_q;
    err_d        = 1'b0;
    wr_d         = 1'b0;
    data_d       = data_q;
    unique case (state_q)
      IDLE: begin
        if (enable && win_found) begin
          state_d          = GRANT;
          ack_d[win_idx]   = 1'b1;
          owner_d          = win_idx;
          data_d           = bus.req_data[{win_idx, 3'b000} +: 8];
          active_d         = 1'b1;
        end
      end
      GRANT: begin
        state_d = WRITE;
        wr_d    = 1'b1;
        cnt_d   = '0;
      end
      WRITE: begin
        state_d = WAIT_START;
      end
      WAIT_START: begin
        if (bus.tx_busy) begin
          state_d = WAIT_DONE;
        end else if (cnt_q + 1'b1 == CNT_LAST) begin
          err_d        = 1'b1;
          last_grant_d = owner_q;
          active_d     = 1'b0;
          state_d      = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!bus.tx_busy) begin
          done_d[owner_q] = 1'b1;
          last_grant_d    = owner_q;
          active_d        = 1'b0;
          state_d         = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers. Reset is asynchronous, so an in-flight
  // frame is abandoned at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      last_grant_q <= LAST_RST;
      cnt_q        <= '0;
      ack_q        <= '0;
      done_q       <= '0;
      owner_q      <= '0;
      active_q     <= 1'b0;
      err_q        <= 1'b0;
      wr_q         <= 1'b0;
      en_q         <= 1'b0;
      data_q       <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      ack_q        <= ack_d;
      done_q       <= done_d;
      owner_q      <= owner_d;
      active_q     <= active_d;
      err_q        <= err_d;
      wr_q         <= wr_d;
      en_q         <= enable;
      data_q       <= data_d;
    end
  end

  assign bus.ack     = ack_q;
  assign bus.done    = done_q;
  assign bus.tx_en   = en_q;
  assign bus.tx_wr   = wr_q;
  assign bus.tx_data = data_q;
  assign cur_owner   = owner_q;
  assign active      = active_q;
  assign err_timeout = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter. A single thread drives the
// requesters and a simple transmitter busy model. On every negative clock
// edge it compares the DUT outputs against the queue of expected grants.
module tb_uart_tx_arbiter;

  localparam int NREQ  = 4;
  localparam int PTR_W = 2;
  localparam int ST    = 16;

  typedef struct {
    int         owner;
    logic [7:0] data;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             enable = 1'b0;
  logic [PTR_W-1:0] cur_owner;
  logic             active;
  logic             err_timeout;

  uart_tx_arbiter_if #(.NREQ(NREQ)) bus ();

  uart_tx_arbiter #(
    .NREQ(NREQ),
    .PTR_W(PTR_W),
    .START_TIMEOUT(ST)
  ) dut (
    .clk(clk),
    .rst(rst),
    .enable(enable),
    .bus(bus.slave),
    .cur_owner(cur_owner),
    .active(active),
    .err_timeout(err_timeout)
  );

  initial forever #5 clk = ~clk;

  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  exp_t exp_q[$];

  int         ack_cnt, done_cnt, err_cnt;
  int         ack_cyc, wr_cyc, fall_cyc;
  int         rise_at, fall_at;
  int         own_track;
  logic       prev_wr;
  logic       busy_en, drop_on_ack;
  logic [3:0] ack_mask;
  logic [7:0] cur_data;
  int         reassert_left[NREQ];
  logic       rearm[NREQ];
  int         e_cyc, en_cyc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push(input int o, input logic [7:0] d);
    exp_t e;
    e.owner = o;
    e.data  = d;
    exp_q.push_back(e);
  endtask

  task automatic clear_counts();
    ack_cnt   = 0;
    done_cnt  = 0;
    err_cnt   = 0;
    ack_mask  = '0;
    own_track = -1;
    for (int i = 0; i < NREQ; i++) begin
      reassert_left[i] = 0;
      rearm[i]         = 1'b0;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ack"}, 32'(bus.ack), 0);
    check({tag, "_done"}, 32'(bus.done), 0);
    check({tag, "_owner"}, 32'(cur_owner), 0);
    check({tag, "_active"}, 32'(active), 0);
    check({tag, "_err"}, 32'(err_timeout), 0);
    check({tag, "_tx_en"}, 32'(bus.tx_en), 0);
    check({tag, "_tx_wr"}, 32'(bus.tx_wr), 0);
    check({tag, "_tx_data"}, 32'(bus.tx_data), 0);
  endtask

  // One clock: sample the DUT at the falling edge, score it, then update
  // the requesters and the transmitter busy model for the next rising edge.
  task automatic step();
    exp_t e;
    @(negedge clk);
    cyc++;
    if (bus.ack != '0) begin
      ack_cnt++;
      ack_cyc  = cyc;
      ack_mask = ack_mask | bus.ack;
      if (exp_q.size() == 0) begin
        check("ack_unexpected", 32'(bus.ack), 0);
      end else begin
        e = exp_q.pop_front();
        check("ack_owner", 32'(bus.ack), 32'(1) << e.owner);
        check("grant_owner", 32'(cur_owner), 32'(e.owner));
        check("grant_data", 32'(bus.tx_data), 32'(e.data));
        check("grant_active", 32'(active), 1);
        cur_data = e.data;
      end
    end
    if (bus.done != '0) begin
      done_cnt++;
      check("done_owner", 32'(bus.done), 32'(1) << cur_owner);
      check("done_active", 32'(active), 0);
      check("ack_done_overlap", 32'(bus.ack & bus.done), 0);
      check("tx_data_hold", 32'(bus.tx_data), 32'(cur_data));
      if (busy_en) check("done_lat", cyc, fall_cyc + 1);
    end
    if (bus.tx_wr) begin
      wr_cyc = cyc;
      check("wr_lat", cyc, ack_cyc + 1);
      check("wr_pulse", 32'(prev_wr), 0);
    end
    if (err_timeout) begin
      err_cnt++;
      check("to_lat", cyc, wr_cyc + ST);
      check("to_active", 32'(active), 0);
    end
    if (own_track >= 0 && active) check("owner_hold", 32'(cur_owner), 32'(own_track));
    prev_wr = bus.tx_wr;

    // requesters: re-raise a previously dropped request, then drop on ack
    for (int i = 0; i < NREQ; i++) begin
      if (rearm[i]) begin
        bus.req[i] = 1'b1;
        rearm[i]   = 1'b0;
      end
    end
    if (drop_on_ack && bus.ack != '0) begin
      for (int i = 0; i < NREQ; i++) begin
        if (bus.ack[i]) begin
          bus.req[i] = 1'b0;
          if (reassert_left[i] > 0) begin
            reassert_left[i]--;
            rearm[i] = 1'b1;
          end
        end
      end
    end
    if (bus.ack != '0 && exp_q.size() == 0) begin
      bus.req = '0;
      for (int i = 0; i < NREQ; i++) rearm[i] = 1'b0;
    end

    // transmitter: busy two cycles after the strobe, for twenty cycles
    if (busy_en && bus.tx_wr) begin
      rise_at = cyc + 2;
      fall_at = cyc + 22;
    end
    if (cyc == rise_at) bus.tx_busy = 1'b1;
    if (cyc == fall_at) begin
      bus.tx_busy = 1'b0;
      fall_cyc    = cyc;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.req      = '0;
    bus.req_data = '0;
    bus.tx_busy  = 1'b0;
    ack_cyc = -100; wr_cyc = -100; fall_cyc = -100;
    rise_at = -1;   fall_at = -1;
    prev_wr = 1'b0; busy_en = 1'b1; drop_on_ack = 1'b1;
    cur_data = '0;
    clear_counts();

    // reset state
    repeat (3) step();
    check_all_zero("reset");
    rst    = 1'b1;
    enable = 1'b1;
    step();
    step();
    check("tx_en_on", 32'(bus.tx_en), 1);

    // single request from requester 1
    clear_counts();
    bus.req_data = {8'h44, 8'h33, 8'hA5, 8'h11};
    push(1, 8'hA5);
    own_track = 1;
    bus.req   = 4'b0010;
    for (int i = 0; i < 60 && done_cnt < 1; i++) step();
    check("s1_acks", ack_cnt, 1);
    check("s1_dones", done_cnt, 1);
    check("s1_owner", 32'(cur_owner), 1);
    check("s1_queue", exp_q.size(), 0);

    // all four request right after reset; each drops on ack, then re-raises once
    rst = 1'b0;
    step();
    rst = 1'b1;
    clear_counts();
    bus.req_data = {8'h44, 8'h33, 8'h22, 8'h11};
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < NREQ; i++) push(i, bus.req_data[8*i +: 8]);
    end
    for (int i = 0; i < NREQ; i++) reassert_left[i] = 1;
    bus.req = 4'b1111;
    for (int i = 0; i < 300 && done_cnt < 8; i++) step();
    check("s2_acks", ack_cnt, 8);
    check("s2_dones", done_cnt, 8);
    check("s2_queue", exp_q.size(), 0);

    // fairness: requesters 0 and 2 hold req continuously
    clear_counts();
    drop_on_ack  = 1'b0;
    bus.req_data = {8'h9C, 8'h5A, 8'h3C, 8'hC3};
    push(0, 8'hC3); push(2, 8'h5A); push(0, 8'hC3); push(2, 8'h5A);
    bus.req = 4'b0101;
    for (int i = 0; i < 200 && done_cnt < 4; i++) step();
    check("s3_dones", done_cnt, 4);
    check("s3_no_1_3", 32'(ack_mask & 4'b1010), 0);
    check("s3_queue", exp_q.size(), 0);

    // timeout: transmitter never goes busy, requester 1 waits behind 0
    clear_counts();
    drop_on_ack  = 1'b1;
    busy_en      = 1'b0;
    bus.req_data = {8'h04, 8'h03, 8'h02, 8'h01};
    push(0, 8'h01);
    bus.req = 4'b0001;
    for (int i = 0; i < 10 && ack_cnt < 1; i++) step();
    push(1, 8'h02);
    bus.req[1] = 1'b1;
    for (int i = 0; i < 40 && err_cnt < 1; i++) step();
    check("s4_err1", err_cnt, 1);
    e_cyc = cyc;
    for (int i = 0; i < 10 && ack_cnt < 2; i++) step();
    // the edge after the error cycle samples the pending request
    check("s4_next_ack", cyc, e_cyc + 1);
    for (int i = 0; i < 40 && err_cnt < 2; i++) step();
    check("s4_err2", err_cnt, 2);
    check("s4_no_done", done_cnt, 0);
    check("s4_queue", exp_q.size(), 0);

    // enable drops during WAIT_DONE with requester 3 pending
    clear_counts();
    busy_en      = 1'b1;
    bus.req_data = {8'hD4, 8'hD3, 8'hD2, 8'hD1};
    push(0, 8'hD1);
    bus.req = 4'b0001;
    for (int i = 0; i < 20 && !bus.tx_busy; i++) step();
    check("s5_busy_seen", 32'(bus.tx_busy), 1);
    step();
    enable = 1'b0;
    push(3, 8'hD4);
    bus.req[3] = 1'b1;
    for (int i = 0; i < 40 && done_cnt < 1; i++) step();
    check("s5_done", done_cnt, 1);
    repeat (10) step();
    check("s5_no_ack_disabled", ack_cnt, 1);
    check("s5_tx_en_off", 32'(bus.tx_en), 0);
    check("s5_active_off", 32'(active), 0);
    enable = 1'b1;
    en_cyc = cyc;
    for (int i = 0; i < 10 && ack_cnt < 2; i++) step();
    // enable is first sampled at the next rising edge; ack follows that edge
    check("s5_ack_after_en", cyc, en_cyc + 1);
    for (int i = 0; i < 40 && done_cnt < 2; i++) step();
    check("s5_done2", done_cnt, 2);
    check("s5_queue", exp_q.size(), 0);

    // reset while requester 2 is in WAIT_DONE, after requester 1 was served
    clear_counts();
    bus.req_data = {8'hE4, 8'hE3, 8'hE2, 8'hE1};
    push(1, 8'hE2);
    bus.req = 4'b0010;
    for (int i = 0; i < 40 && done_cnt < 1; i++) step();
    check("s6_first_done", done_cnt, 1);
    push(2, 8'hE3);
    bus.req = 4'b0100;
    for (int i = 0; i < 20 && !bus.tx_busy; i++) step();
    step();
    check("s6_busy_seen", 32'(bus.tx_busy), 1);
    check("s6_active_pre", 32'(active), 1);
    rst = 1'b0;
    #1;
    check_all_zero("midrst");
    bus.tx_busy = 1'b0;
    rise_at     = -1;
    fall_at     = -1;
    repeat (2) step();
    check_all_zero("midrst_hold");
    rst = 1'b1;
    push(0, 8'hE1);
    push(3, 8'hE4);
    bus.req = 4'b1001;
    for (int i = 0; i < 80 && done_cnt < 3; i++) step();
    check("s6_dones", done_cnt, 3);
    check("s6_queue", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
